// File: rtl/mult_control.sv
// mult_control: sequencer for a shift-and-add unsigned multiplier built
// around an external combinational Adder (two WIDTH-bit operands, WIDTH+1-bit
// sum). A start request latches both operands. The block then drives the
// Adder once per cycle for WIDTH iterations, accumulating a 2*WIDTH-bit
// product, and raises Done for one cycle when the product is final.
//
// Ports:
//   Clk            system clock, rising edge
//   Reset_n        synchronous active-low reset
//   St             start request, honoured only in IDLE
//   Multiplicando  multiplicand, captured on the accepting edge
//   Multiplicador  multiplier, captured on the accepting edge
//   OperandoA/B    operands driven to the external Adder
//   Soma           WIDTH+1-bit sum returned by the Adder
//   Produto        product register
//   Busy           high while iterating
//   Done           one-cycle completion pulse
module mult_control #(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               St,
  input  logic [WIDTH-1:0]   Multiplicando,
  input  logic [WIDTH-1:0]   Multiplicador,
  output logic [WIDTH-1:0]   OperandoA,
  output logic [WIDTH-1:0]   OperandoB,
  input  logic [WIDTH:0]     Soma,
  output logic [2*WIDTH-1:0] Produto,
  output logic               Busy,
  output logic               Done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (St) state_d = S_CALC;
      S_CALC:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath update. The high half of P is the running partial sum and the
  // low half is the multiplier, which is shifted out LSB first. The adder
  // carry Soma[WIDTH] lands in P[2*WIDTH-1] after the shift, so no bit of
  // the product is lost.
  always_comb begin
    p_d     = p_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (St) begin
          p_d     = {{WIDTH{1'b0}}, Multiplicador};
          mcand_d = Multiplicando;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        if (p_q[0]) p_d = {Soma, p_q[WIDTH-1:1]};
        else        p_d = {1'b0, p_q[2*WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs. Outside CALC the Adder sees zeros.
  always_comb begin
    OperandoA = '0;
    OperandoB = '0;
    Busy      = 1'b0;
    Done      = 1'b0;
    unique case (state_q)
      S_CALC: begin
        OperandoA = p_q[2*WIDTH-1:WIDTH];
        OperandoB = p_q[0] ? mcand_q : '0;
        Busy      = 1'b1;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  assign Produto = p_q;

endmodule

// File: tb/tb_mult_control.sv
module tb_mult_control;
  localparam int W = 16;

  logic           Clk = 1'b0;
  logic           Reset_n = 1'b0;
  logic           St = 1'b0;
  logic [W-1:0]   Multiplicando = '0;
  logic [W-1:0]   Multiplicador = '0;
  logic [W-1:0]   OperandoA, OperandoB;
  logic [W:0]     Soma;
  logic [2*W-1:0] Produto;
  logic           Busy, Done;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected products, pushed at start, popped at Done.
  logic [2*W-1:0] exp_q[$];

  // Observations gathered by the monitor.
  int done_cnt  = 0;
  bit carry_seen = 0;
  bit opb_nz     = 0;

  always #5 Clk = ~Clk;

  // Behavioural stand-in for the external Adder.
  assign Soma = {1'b0, OperandoA} + {1'b0, OperandoB};

  mult_control #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .St(St),
    .Multiplicando(Multiplicando), .Multiplicador(Multiplicador),
    .OperandoA(OperandoA), .OperandoB(OperandoB), .Soma(Soma),
    .Produto(Produto), .Busy(Busy), .Done(Done)
  );

  always @(negedge Clk) begin
    if (Done) done_cnt++;
    if (Busy && Soma[W]) carry_seen = 1;
    if (Busy && OperandoB != '0) opb_nz = 1;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Drive one accepted start edge and queue the expected product.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    Multiplicando = a;
    Multiplicador = b;
    St = 1'b1;
    step();
    St = 1'b0;
    exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
  endtask

  // Advance until Done is visible (bounded); report edges and Busy cycles.
  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    while (!Done && cyc < 40) begin
      if (Busy) busy_n++;
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    step();
    step();
    checks++;
    if (Produto !== '0 || Busy !== 1'b0 || Done !== 1'b0 ||
        OperandoA !== '0 || OperandoB !== '0) begin
      errors++;
      $display("FAIL reset: P=%h Busy=%b Done=%b A=%h B=%h required all 0",
               Produto, Busy, Done, OperandoA, OperandoB);
    end
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int cyc, busy_n, d0;
    logic [2*W-1:0] e;
    d0 = done_cnt;
    start_op(16'd10, 16'd20);
    wait_done(cyc, busy_n);
    e = exp_q.pop_front();
    checks++;
    if (cyc !== 16) begin
      errors++;
      $display("FAIL basic_latency: done after %0d edges past start, required 16", cyc);
    end
    checks++;
    if (busy_n !== 16) begin
      errors++;
      $display("FAIL basic_busy: busy %0d cycles, required 16", busy_n);
    end
    checks++;
    if (Produto !== e || e !== 32'd200) begin
      errors++;
      $display("FAIL basic_product: got %h required %h", Produto, e);
    end
    step();
    checks++;
    if (Done !== 1'b0 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL basic_done_pulse: Done=%b pulses=%0d required 0/1", Done, done_cnt - d0);
    end
    checks++;
    if (Produto !== e) begin
      errors++;
      $display("FAIL basic_hold: got %h required %h", Produto, e);
    end
  endtask

  task automatic test_max();
    int cyc, busy_n;
    logic [2*W-1:0] e;
    carry_seen = 0;
    start_op(16'hFFFF, 16'hFFFF);
    wait_done(cyc, busy_n);
    e = exp_q.pop_front();
    checks++;
    if (Produto !== e || Done !== 1'b1) begin
      errors++;
      $display("FAIL max_product: got %h Done=%b required %h/1", Produto, Done, e);
    end
    checks++;
    if (!carry_seen) begin
      errors++;
      $display("FAIL max_carry: adder carry seen=%0d required 1", carry_seen);
    end
    step();
  endtask

  task automatic test_patterns();
    int cyc, busy_n;
    logic [2*W-1:0] e;
    start_op(16'h7FFF, 16'h7FFF);
    wait_done(cyc, busy_n);
    e = exp_q.pop_front();
    checks++;
    if (Produto !== e || e !== 32'h3FFF0001) begin
      errors++;
      $display("FAIL 7fff_product: got %h required %h", Produto, e);
    end
    step();
    opb_nz = 0;
    start_op(16'd0, 16'h1234);
    wait_done(cyc, busy_n);
    e = exp_q.pop_front();
    checks++;
    if (Produto !== e || Done !== 1'b1) begin
      errors++;
      $display("FAIL zero_product: got %h Done=%b required %h/1", Produto, Done, e);
    end
    checks++;
    if (opb_nz) begin
      errors++;
      $display("FAIL zero_opb: OperandoB nonzero seen=%0d required 0", opb_nz);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int cyc, busy_n;
    logic [2*W-1:0] e;
    start_op(16'd10, 16'd20);
    repeat (7) step();
    // Mid-operation start with new operands must be ignored.
    Multiplicando = 16'd5;
    Multiplicador = 16'd5;
    St = 1'b1;
    step();
    St = 1'b0;
    wait_done(cyc, busy_n);
    e = exp_q.pop_front();
    checks++;
    if (Produto !== e || e !== 32'd200 || cyc !== 8) begin
      errors++;
      $display("FAIL ignore_st: got %h after %0d edges required %h after 8", Produto, cyc, e);
    end
    // Now in DONE: hold St high, it must start on the first IDLE edge.
    St = 1'b1;
    step();
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Produto !== e) begin
      errors++;
      $display("FAIL held_idle: Busy=%b Done=%b P=%h required 0/0/%h", Busy, Done, Produto, e);
    end
    step();
    exp_q.push_back(32'd25);
    checks++;
    if (Busy !== 1'b1 || Produto !== 32'd5) begin
      errors++;
      $display("FAIL held_start: Busy=%b P=%h required 1/00000005", Busy, Produto);
    end
    St = 1'b0;
    wait_done(cyc, busy_n);
    e = exp_q.pop_front();
    checks++;
    if (Produto !== e || Done !== 1'b1) begin
      errors++;
      $display("FAIL held_product: got %h Done=%b required %h/1", Produto, Done, e);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc, busy_n, d0;
    logic [2*W-1:0] e;
    d0 = done_cnt;
    start_op(16'hFFFF, 16'd2);
    repeat (5) step();
    Reset_n = 1'b0;
    step();
    void'(exp_q.pop_back());
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Produto !== '0 ||
        OperandoA !== '0 || OperandoB !== '0) begin
      errors++;
      $display("FAIL midreset: Busy=%b Done=%b P=%h A=%h B=%h required all 0",
               Busy, Done, Produto, OperandoA, OperandoB);
    end
    Reset_n = 1'b1;
    repeat (20) step();
    checks++;
    if (done_cnt !== d0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_nodone: pulses=%0d Busy=%b required 0/0", done_cnt - d0, Busy);
    end
    start_op(16'd3, 16'd4);
    wait_done(cyc, busy_n);
    e = exp_q.pop_front();
    checks++;
    if (Produto !== e || e !== 32'd12 || cyc !== 16) begin
      errors++;
      $display("FAIL restart: got %h after %0d edges required %h after 16", Produto, cyc, e);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d entries remain, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
